lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 43 ++++
 rtl/lsu.sv | 212 +++++++++++++++++++++
 tb/tb_lsu.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
// master: the lsu itself. slave: the execute/writeback/memory environment.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

interface lsu_if;
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1. valid holds its payload stable until that edge. dmem_req
    // holds address/controls stable until the edge where dmem_ack is 1.
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_store;
    logic [2:0]           req_funct3;
    logic [`WORD_LEN-1:0] req_addr;
    logic [`WORD_LEN-1:0] req_wdata;
    logic                 flush;
    logic                 dmem_req;
    logic                 dmem_we;
    logic [`WORD_LEN-1:0] dmem_addr;
    logic [3:0]           dmem_be;
    logic [`WORD_LEN-1:0] dmem_wdata;
    logic                 dmem_ack;
    logic [`WORD_LEN-1:0] dmem_rdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [`WORD_LEN-1:0] resp_rdata;
    logic [1:0]           resp_err;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, flush,
        input  dmem_ack, dmem_rdata, resp_ready,
        output req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output resp_valid, resp_rdata, resp_err
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, flush,
        output dmem_ack, dmem_rdata, resp_ready,
        input  req_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, byte-lane steering for stores,
// lane select plus sign/zero extension for loads, and a bus timeout.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses return
// resp_err=01 without touching the bus; otherwise the low address bits are
// forced to 0 and the access proceeds.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rstn,
    lsu_if.master      bus,
    output logic [1:0] dbg_state
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int W  = `WORD_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           req_ready_q, req_ready_d;
    logic           dmem_req_q, dmem_req_d;
    logic           dmem_we_q, dmem_we_d;
    logic [W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [3:0]     dmem_be_q, dmem_be_d;
    logic [W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic           resp_valid_q, resp_valid_d;
    logic [W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]     resp_err_q, resp_err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     f3_q, f3_d;
    logic [1:0]     lane_q, lane_d;

    logic           illegal;
    logic           misaligned;
    logic [1:0]     lane_in;
    logic [3:0]     be_in;
    logic [W-1:0]   wdata_in;
    logic [W-1:0]   rd_shift;
    logic [W-1:0]   load_val;
    logic           timeout_hit;

    // Request decode: legality, alignment, lane and byte-enable generation.
    always_comb begin
        illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111) || (bus.req_funct3[2] && bus.req_store);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        // Halfwords snap to an even lane and words to lane 0 when not trapping.
        case (bus.req_funct3[1:0])
            2'b01:   lane_in = {bus.req_addr[1], 1'b0};
            2'b10:   lane_in = 2'b00;
            default: lane_in = bus.req_addr[1:0];
        endcase
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_in    = 4'b0001 << lane_in;
                wdata_in = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << lane_in;
                wdata_in = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = bus.req_wdata;
            end
        endcase
    end

    // Load data path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        rd_shift = bus.dmem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{(W-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{(W-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_val = {{(W-8){1'b0}}, rd_shift[7:0]};
            3'b101:  load_val = {{(W-16){1'b0}}, rd_shift[15:0]};
            default: load_val = bus.dmem_rdata;
        endcase
        timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end

    // Next-state and next-output logic of the IDLE/BUS/RESP/DRAIN controller.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        case (state_q)
            IDLE: begin
                // A flush in the same cycle blocks acceptance.
                if (bus.req_valid && req_ready_q && !bus.flush) begin
                    f3_d         = bus.req_funct3;
                    lane_d       = lane_in;
                    cnt_d        = '0;
                    resp_rdata_d = '0;
                    req_ready_d  = 1'b0;
                    if (illegal || misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = illegal ? 2'b11 : 2'b01;
                    end else begin
                        state_d      = BUS;
                        resp_err_d   = 2'b00;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = bus.req_store;
                        dmem_addr_d  = {bus.req_addr[W-1:2], 2'b00};
                        dmem_be_d    = be_in;
                        dmem_wdata_d = wdata_in;
                    end
                end
            end
            BUS: begin
                if (bus.dmem_ack || timeout_hit) begin
                    dmem_req_d = 1'b0;
                    if (bus.flush) begin
                        state_d     = IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = bus.dmem_ack ? 2'b00 : 2'b10;
                        resp_rdata_d = (bus.dmem_ack && !dmem_we_q) ? load_val : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (bus.flush) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Bus request stays up until the memory finishes; result is dropped.
                if (bus.dmem_ack || timeout_hit) begin
                    dmem_req_d  = 1'b0;
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready || bus.flush) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any bus request at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 2'b00;
            cnt_q        <= '0;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases followed by random accesses, all checked
// against an arithmetic model of lane steering, extension and error codes.
module tb_lsu;
  localparam int TO = 4;

  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;
  logic [33:0] exp_q[$];

  lsu_if bus_if();

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus_if),
    .dbg_state(dbg_state)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(input logic st, input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]);
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (int'(addr[1:0]) % op_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
    int sz = op_size(f3);
    return (int'(addr[1:0]) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz = op_size(f3);
    return 32'(((1 << sz) - 1) << lane_off(f3, addr));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = op_size(f3);
    logic [63:0] mask = (64'd1 << (8 * sz)) - 64'd1;
    logic [63:0] w = 64'd0;
    for (int i = 0; i < 4; i += sz) w = w | ((64'(wd) & mask) << (8 * i));
    return w[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int sz = op_size(f3);
    logic [63:0] mask = (64'd1 << (8 * sz)) - 64'd1;
    logic [63:0] v = (64'(rd) >> (8 * lane_off(f3, addr))) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // drivers
  task automatic idle_inputs();
    bus_if.req_valid  = 1'b0;
    bus_if.req_store  = 1'b0;
    bus_if.req_funct3 = 3'd0;
    bus_if.req_addr   = 32'd0;
    bus_if.req_wdata  = 32'd0;
    bus_if.flush      = 1'b0;
    bus_if.dmem_ack   = 1'b0;
    bus_if.dmem_rdata = 32'd0;
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    check("req_ready_before_issue", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid  = 1'b1;
    bus_if.req_store  = st;
    bus_if.req_funct3 = f3;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wd;
    @(negedge clk);
    bus_if.req_valid  = 1'b0;
    bus_if.req_wdata  = $urandom;
  endtask

  // d = bus cycle in which ack is given; d >= TO means no ack (timeout)
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int d,
                       input bit hold);
    logic [1:0]  err;
    logic [31:0] exp_rd;
    logic [33:0] e;
    bit done = 1'b0;
    issue(st, f3, addr, wd);
    if (is_illegal(st, f3)) begin
      err = 2'b11; exp_rd = 32'd0;
      check("no_bus_on_error", 32'(bus_if.dmem_req), 32'd0);
    end else if (is_mis(f3, addr)) begin
      err = 2'b01; exp_rd = 32'd0;
      check("no_bus_on_error", 32'(bus_if.dmem_req), 32'd0);
    end else begin
      check("dmem_we", 32'(bus_if.dmem_we), 32'(st));
      check("dmem_addr", bus_if.dmem_addr, addr & ~32'd3);
      check("dmem_be", 32'(bus_if.dmem_be), model_be(f3, addr));
      if (st) check("dmem_wdata", bus_if.dmem_wdata, model_wdata(f3, wd));
      check("req_ready_busy", 32'(bus_if.req_ready), 32'd0);
      for (int k = 0; k <= TO && !done; k++) begin
        check("dmem_req_held", 32'(bus_if.dmem_req), 32'd1);
        check("dmem_addr_held", bus_if.dmem_addr, addr & ~32'd3);
        check("resp_valid_in_bus", 32'(bus_if.resp_valid), 32'd0);
        if (k == d) begin
          bus_if.dmem_ack = 1'b1;
          bus_if.dmem_rdata = rd;
          @(negedge clk);
          bus_if.dmem_ack = 1'b0;
          bus_if.dmem_rdata = $urandom;
          done = 1'b1;
        end else if (k == TO - 1) begin
          @(negedge clk);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
      if (d < TO) begin
        err = 2'b00; exp_rd = st ? 32'd0 : model_load(f3, addr, rd);
      end else begin
        err = 2'b10; exp_rd = 32'd0;
      end
    end
    exp_q.push_back({err, exp_rd});
    check("dmem_req_after", 32'(bus_if.dmem_req), 32'd0);
    check("resp_valid", 32'(bus_if.resp_valid), 32'd1);
    if (hold) begin
      @(negedge clk);
      check("resp_valid_hold", 32'(bus_if.resp_valid), 32'd1);
    end
    e = exp_q.pop_front();
    check("resp_rdata", bus_if.resp_rdata, e[31:0]);
    check("resp_err", 32'(bus_if.resp_err), 32'(e[33:32]));
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    check("resp_valid_done", 32'(bus_if.resp_valid), 32'd0);
    check("req_ready_done", 32'(bus_if.req_ready), 32'd1);
  endtask

  // directed steps then random traffic
  initial begin
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dmem_req", 32'(bus_if.dmem_req), 32'd0);
    check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus_if.resp_err), 32'd0);
    check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
    check("rst_dmem_be", 32'(bus_if.dmem_be), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", 32'(bus_if.req_ready), 32'd1);

    // LB 0x103, ack after 2 cycles
    do_op(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FF00, 2, 1'b0);
    // SH 0x202 wdata 0xBEEF
    do_op(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'd0, 1, 1'b1);
    // LW 0x101: trap or aligned-down access depending on build
    do_op(1'b0, 3'b010, 32'h101, 32'd0, 32'h1234_5678, 0, 1'b0);
    // LHU 0x0 with no ack -> timeout
    do_op(1'b0, 3'b101, 32'h0, 32'd0, 32'd0, TO, 1'b0);
    // illegal funct3 and store with unsigned code
    do_op(1'b0, 3'b011, 32'h40, 32'd0, 32'd0, 0, 1'b0);
    do_op(1'b1, 3'b100, 32'h41, 32'h55, 32'd0, 0, 1'b0);
    // ack on the last cycle before timeout still counts
    do_op(1'b0, 3'b001, 32'h22, 32'd0, 32'h8001_7FFF, TO - 1, 1'b0);

    // flush in BUS: request held to ack, no response
    issue(1'b0, 3'b010, 32'h300, 32'd0);
    check("flush_bus_req", 32'(bus_if.dmem_req), 32'd1);
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    check("drain_req_held", 32'(bus_if.dmem_req), 32'd1);
    check("drain_no_valid", 32'(bus_if.resp_valid), 32'd0);
    bus_if.dmem_ack = 1'b1;
    bus_if.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_if.dmem_ack = 1'b0;
    check("drain_req_dropped", 32'(bus_if.dmem_req), 32'd0);
    check("drain_ready", 32'(bus_if.req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("drain_valid_never", 32'(bus_if.resp_valid), 32'd0);
      @(negedge clk);
    end

    // flush in RESP drops the response without handshake
    issue(1'b0, 3'b111, 32'h8, 32'd0);
    check("resp_before_flush", 32'(bus_if.resp_valid), 32'd1);
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    check("resp_flushed", 32'(bus_if.resp_valid), 32'd0);
    check("resp_flush_ready", 32'(bus_if.req_ready), 32'd1);

    // flush in IDLE blocks acceptance
    bus_if.req_valid = 1'b1;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr = 32'h500;
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.flush = 1'b0;
    check("idle_flush_no_req", 32'(bus_if.dmem_req), 32'd0);
    check("idle_flush_no_valid", 32'(bus_if.resp_valid), 32'd0);
    check("idle_flush_ready", 32'(bus_if.req_ready), 32'd1);

    // stray ack in IDLE is ignored
    bus_if.dmem_ack = 1'b1;
    @(negedge clk);
    bus_if.dmem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_valid", 32'(bus_if.resp_valid), 32'd0);
    check("stray_ack_ready", 32'(bus_if.req_ready), 32'd1);

    // reset during BUS abandons the access
    issue(1'b0, 3'b010, 32'h600, 32'd0);
    check("pre_rst_req", 32'(bus_if.dmem_req), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_if.dmem_req), 32'd0);
    check("mid_rst_valid", 32'(bus_if.resp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus_if.req_ready), 32'd1);
    do_op(1'b0, 3'b010, 32'h604, 32'd0, 32'hCAFE_F00D, 1, 1'b0);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom, $urandom_range(0, TO), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
